cotm32_csr_unit: RTL and testbench
==================================

COTM32_CSR_UNIT -- requirements
Module: cotm32_csr_unit

Interface
REQ-001 SHALL have parameter RESET_MTVEC, default 32'h0000_0000: mtvec value after reset; bits [1:0] ignored.
REQ-002 SHALL have ports:
  - clk  in  1  clock; all state updates on its rising edge.
  - rst  in  1  asynchronous, active-high reset.
  - csr_en  in  1  Zicsr instruction valid this cycle.
  - csr_op  in  zicsr_csr_op_t  RW/RS/RC.
  - csr_addr  in  12  CSR address.
  - csr_wdata  in  MXLEN  operand, already muxed from rs1 or zero-extended immediate.
  - csr_wr_suppress  in  1  RS/RC with rs1=x0 or uimm=0; read-only access.
  - csr_rdata  out  MXLEN  old CSR value, combinational.
  - csr_illegal  out  1  csr_en with an unimplemented address.
  - trap_req  in  1  trap request.
  - trap_cause  in  trap_cause_t  cause code.
  - trap_pc  in  MXLEN  PC of the faulting instruction.
  - trap_val  in  MXLEN  mtval payload.
  - mret  in  1  MRET executing.
  - redirect_valid  out  1  one-cycle PC redirect pulse, registered.
  - redirect_pc  out  MXLEN  redirect target, registered.

Function
REQ-003 SHALL implement MTVEC, MEPC, MCAUSE and MTVAL at the addresses in cotm32_priv_pkg.
REQ-004 SHALL drive csr_rdata with the pre-write value of the addressed CSR in the same cycle; 0 when unimplemented.
REQ-005 SHALL compute the new value as RW: wdata; RS: old|wdata; RC: old&~wdata; the value is committed at the next clk edge.
REQ-006 SHALL perform no write when csr_wr_suppress=1 and op is RS or RC; RW always writes.
REQ-007 SHALL assert csr_illegal combinationally when csr_en=1 and the address is unimplemented, and SHALL perform no write in that case.
REQ-008 SHALL force mtvec[1:0] and mepc[1:0] to 2'b00 on every write (direct mode only, no compressed instructions).
REQ-009 SHALL have FSM states IDLE and REDIRECT; the FSM SHALL reset to IDLE.
REQ-010 SHALL, in IDLE when trap_req=1, load mepc<=trap_pc, mcause<=trap_cause and mtval<=trap_val; drive redirect_pc<=mtvec; and enter REDIRECT.
REQ-011 SHALL, in IDLE when mret=1 and trap_req=0, drive redirect_pc<=mepc and enter REDIRECT; no CSR changes.
REQ-012 SHALL assert redirect_valid=1 only in REDIRECT, then return unconditionally to IDLE after one cycle.
REQ-013 SHALL ignore trap_req, mret and csr_en writes while in REDIRECT, because the pipeline is flushing.
REQ-014 SHALL apply priority trap_req > mret > CSR write in the same IDLE cycle; the losing CSR write is dropped.
REQ-015 SHALL use for redirect_pc the mtvec value before any same-cycle CSR write.

Reset
REQ-016 SHALL, on rst asserted, immediately set mtvec=RESET_MTVEC&~3, mepc=0, mcause=0, mtval=0, state=IDLE, redirect_valid=0 and redirect_pc=0.
REQ-017 SHALL, on rst asserted during REDIRECT, abort the redirect pulse within that cycle.

Configuration
REQ-018 SHALL, when COTM32_CSR_MSCRATCH_EN is defined, implement MSCRATCH (12'h340) as a plain 32-bit RW/RS/RC register with reset value 0.
REQ-019 SHALL, when COTM32_CSR_MSCRATCH_EN is undefined, treat 12'h340 as unimplemented, so csr_illegal=1 and the read returns 0.

Structure
REQ-020 SHALL take trap_cause_t, zicsr_csr_addr_t (extended with ZICSR_CSR_MSCRATCH=12'h340), zicsr_csr_op_t and MXLEN from cotm32_priv_pkg; no local copies.
REQ-021 SHALL place the RW/RS/RC new-value function in sub-module cotm32_csr_alu, which is purely combinational.

Verification
REQ-022 SHALL cover: CSRRW mtvec, wdata 32'h8000_0103 -> rdata=old 0; next read 32'h8000_0100.
REQ-023 SHALL cover: mcause=32'hF0; CSRRC with wdata 32'h30 -> mcause=32'hC0; repeat with suppress=1 -> unchanged.
REQ-024 SHALL cover: trap_req, cause ILLEGAL_INST, pc 32'h1004, val 32'hDEAD, with mtvec=32'h200 -> next cycle redirect_valid=1, redirect_pc=32'h200, mepc=32'h1004, mcause=2, mtval=32'hDEAD; following cycle redirect_valid=0.
REQ-025 SHALL cover: trap_req, mret and CSRRW mtvec all in one cycle -> trap taken, mtvec unchanged; mret or trap issued during REDIRECT -> ignored.
REQ-026 SHALL cover: mret with mepc=32'h1008 -> redirect_pc=32'h1008; rst asserted in REDIRECT -> redirect_valid drops at once, all CSRs reset.
REQ-027 SHALL cover: CSRRS to 12'h340 -> csr_illegal=1 without the macro, and a working register with it.

Source files
------------

// File: rtl/cotm32_priv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cotm32_priv_pkg
// Description : Machine-mode privileged definitions shared by the COTM32 core:
//               XLEN, Zicsr operation and address encodings, trap causes.
// Revision    : 1.0 - initial release
// ============================================================================
package cotm32_priv_pkg;

   localparam int MXLEN = 32;

   // Implemented machine-mode CSR addresses
   typedef enum logic [11:0] {
      ZICSR_CSR_MTVEC    = 12'h305,
      ZICSR_CSR_MSCRATCH = 12'h340,
      ZICSR_CSR_MEPC     = 12'h341,
      ZICSR_CSR_MCAUSE   = 12'h342,
      ZICSR_CSR_MTVAL    = 12'h343
   } zicsr_csr_addr_t;

   // Zicsr operation, encoded as funct3[1:0]; 2'b00 never writes
   typedef enum logic [1:0] {
      ZICSR_CSR_OP_NONE = 2'b00,
      ZICSR_CSR_OP_RW   = 2'b01,
      ZICSR_CSR_OP_RS   = 2'b10,
      ZICSR_CSR_OP_RC   = 2'b11
   } zicsr_csr_op_t;

   // mcause encodings; bit MXLEN-1 marks an interrupt
   typedef enum logic [MXLEN-1:0] {
      CAUSE_INST_MISALIGNED = 32'h0000_0000,
      CAUSE_INST_ACCESS     = 32'h0000_0001,
      CAUSE_ILLEGAL_INST    = 32'h0000_0002,
      CAUSE_BREAKPOINT      = 32'h0000_0003,
      CAUSE_LOAD_MISALIGNED = 32'h0000_0004,
      CAUSE_LOAD_ACCESS     = 32'h0000_0005,
      CAUSE_STORE_MISALIGN  = 32'h0000_0006,
      CAUSE_STORE_ACCESS    = 32'h0000_0007,
      CAUSE_ECALL_M         = 32'h0000_000B,
      CAUSE_M_SOFT_INT      = 32'h8000_0003,
      CAUSE_M_TIMER_INT     = 32'h8000_0007,
      CAUSE_M_EXT_INT       = 32'h8000_000B
   } trap_cause_t;

   // Clears bits [1:0]: direct-mode mtvec, no compressed instructions
   localparam logic [MXLEN-1:0] c_align_mask = ~32'h0000_0003;

endpackage
`default_nettype wire

// File: rtl/cotm32_csr_alu.sv
`default_nettype none
// ============================================================================
// Module      : cotm32_csr_alu
// Description : Combinational Zicsr new-value function (RW / RS / RC).
// Revision    : 1.0 - initial release
// ============================================================================
module cotm32_csr_alu
   import cotm32_priv_pkg::*;
(
   input  logic [MXLEN-1:0] old_val,
   input  zicsr_csr_op_t    op,
   input  logic [MXLEN-1:0] wdata,
   output logic [MXLEN-1:0] new_val
);

   // Select the replacement value; unknown op leaves the CSR untouched
   always_comb begin
      new_val = old_val;
      case (op)
         ZICSR_CSR_OP_RW: new_val = wdata;
         ZICSR_CSR_OP_RS: new_val = old_val | wdata;
         ZICSR_CSR_OP_RC: new_val = old_val & ~wdata;
         default:         new_val = old_val;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/cotm32_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : cotm32_csr_unit
// Description : Machine-mode CSR file (mtvec, mepc, mcause, mtval and optional
//               mscratch) with trap entry / MRET redirect sequencer.
//               Define COTM32_CSR_MSCRATCH_EN to implement mscratch (0x340).
// Revision    : 1.0 - initial release
// ============================================================================
module cotm32_csr_unit
   import cotm32_priv_pkg::*;
#(
   parameter logic [MXLEN-1:0] RESET_MTVEC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              csr_en,
   input  zicsr_csr_op_t     csr_op,
   input  logic [11:0]       csr_addr,
   input  logic [MXLEN-1:0]  csr_wdata,
   input  logic              csr_wr_suppress,
   output logic [MXLEN-1:0]  csr_rdata,
   output logic              csr_illegal,
   input  logic              trap_req,
   input  trap_cause_t       trap_cause,
   input  logic [MXLEN-1:0]  trap_pc,
   input  logic [MXLEN-1:0]  trap_val,
   input  logic              mret,
   output logic              redirect_valid,
   output logic [MXLEN-1:0]  redirect_pc
);

   typedef enum logic [0:0] {
      IDLE     = 1'b0,
      REDIRECT = 1'b1
   } state_t;

   state_t           r_state;
   logic [MXLEN-1:0] r_mtvec;
   logic [MXLEN-1:0] r_mepc;
   logic [MXLEN-1:0] r_mcause;
   logic [MXLEN-1:0] r_mtval;
`ifdef COTM32_CSR_MSCRATCH_EN
   logic [MXLEN-1:0] r_mscratch;
`endif
   logic             r_redirect_valid;
   logic [MXLEN-1:0] r_redirect_pc;

   logic [MXLEN-1:0] w_rdata;
   logic             w_impl;
   logic [MXLEN-1:0] w_new;
   logic             w_write_op;
   logic             w_take_trap;
   logic             w_take_mret;
   logic             w_csr_we;

   // Address decode and pre-write read mux; unimplemented reads return 0
   always_comb begin
      w_rdata = '0;
      w_impl  = 1'b0;
      case (csr_addr)
         ZICSR_CSR_MTVEC:    begin w_rdata = r_mtvec;    w_impl = 1'b1; end
         ZICSR_CSR_MEPC:     begin w_rdata = r_mepc;     w_impl = 1'b1; end
         ZICSR_CSR_MCAUSE:   begin w_rdata = r_mcause;   w_impl = 1'b1; end
         ZICSR_CSR_MTVAL:    begin w_rdata = r_mtval;    w_impl = 1'b1; end
`ifdef COTM32_CSR_MSCRATCH_EN
         ZICSR_CSR_MSCRATCH: begin w_rdata = r_mscratch; w_impl = 1'b1; end
`endif
         default:            begin w_rdata = '0;         w_impl = 1'b0; end
      endcase
   end

   assign csr_rdata   = w_rdata;
   assign csr_illegal = csr_en & ~w_impl;

   cotm32_csr_alu u_alu (
      .old_val (w_rdata),
      .op      (csr_op),
      .wdata   (csr_wdata),
      .new_val (w_new)
   );

   // RW always writes; RS/RC with a zero source operand are pure reads
   assign w_write_op = (csr_op == ZICSR_CSR_OP_RW) ||
                       (((csr_op == ZICSR_CSR_OP_RS) || (csr_op == ZICSR_CSR_OP_RC)) &&
                        !csr_wr_suppress);

   // Priority trap > mret > CSR write, and nothing is accepted while flushing
   assign w_take_trap = (r_state == IDLE) && trap_req;
   assign w_take_mret = (r_state == IDLE) && mret && !trap_req;
   assign w_csr_we    = (r_state == IDLE) && csr_en && w_impl && w_write_op &&
                        !trap_req && !mret;

   // CSR storage: trap entry loads the exception state, otherwise software writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mtvec    <= RESET_MTVEC & c_align_mask;
         r_mepc     <= '0;
         r_mcause   <= '0;
         r_mtval    <= '0;
`ifdef COTM32_CSR_MSCRATCH_EN
         r_mscratch <= '0;
`endif
      end else if (w_take_trap) begin
         r_mepc   <= trap_pc & c_align_mask;
         r_mcause <= trap_cause;
         r_mtval  <= trap_val;
      end else if (w_csr_we) begin
         case (csr_addr)
            ZICSR_CSR_MTVEC:    r_mtvec    <= w_new & c_align_mask;
            ZICSR_CSR_MEPC:     r_mepc     <= w_new & c_align_mask;
            ZICSR_CSR_MCAUSE:   r_mcause   <= w_new;
            ZICSR_CSR_MTVAL:    r_mtval    <= w_new;
`ifdef COTM32_CSR_MSCRATCH_EN
            ZICSR_CSR_MSCRATCH: r_mscratch <= w_new;
`endif
            default: ;
         endcase
      end
   end

   // Redirect sequencer: one-cycle registered pulse toward mtvec or mepc
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state          <= IDLE;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_redirect_valid <= 1'b0;
               if (w_take_trap) begin
                  r_redirect_pc    <= r_mtvec;
                  r_redirect_valid <= 1'b1;
                  r_state          <= REDIRECT;
               end else if (w_take_mret) begin
                  r_redirect_pc    <= r_mepc;
                  r_redirect_valid <= 1'b1;
                  r_state          <= REDIRECT;
               end
            end
            REDIRECT: begin
               r_redirect_valid <= 1'b0;
               r_state          <= IDLE;
            end
            default: begin
               r_redirect_valid <= 1'b0;
               r_state          <= IDLE;
            end
         endcase
      end
   end

   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;

endmodule
`default_nettype wire

// File: tb/tb_cotm32_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cotm32_csr_unit
// Description : Self-checking scoreboard bench for cotm32_csr_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cotm32_csr_unit;
   import cotm32_priv_pkg::*;

   localparam int c_k_rdata   = 0;
   localparam int c_k_illegal = 1;
   localparam int c_k_rvalid  = 2;
   localparam int c_k_rpc     = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             csr_en;
   zicsr_csr_op_t    csr_op;
   logic [11:0]      csr_addr;
   logic [MXLEN-1:0] csr_wdata;
   logic             csr_wr_suppress;
   logic [MXLEN-1:0] csr_rdata;
   logic             csr_illegal;
   logic             trap_req;
   trap_cause_t      trap_cause;
   logic [MXLEN-1:0] trap_pc;
   logic [MXLEN-1:0] trap_val;
   logic             mret;
   logic             redirect_valid;
   logic [MXLEN-1:0] redirect_pc;

   always #5 clk = ~clk;

   cotm32_csr_unit #(.RESET_MTVEC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .csr_en          (csr_en),
      .csr_op          (csr_op),
      .csr_addr        (csr_addr),
      .csr_wdata       (csr_wdata),
      .csr_wr_suppress (csr_wr_suppress),
      .csr_rdata       (csr_rdata),
      .csr_illegal     (csr_illegal),
      .trap_req        (trap_req),
      .trap_cause      (trap_cause),
      .trap_pc         (trap_pc),
      .trap_val        (trap_val),
      .mret            (mret),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc)
   );

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      string       tag;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic expect_out(input string tag, input int kind, input logic [31:0] v);
      exp_t e;
      e.tag  = tag;
      e.kind = kind;
      e.exp  = v;
      sb.push_back(e);
   endtask

   // Pop every pending expectation and compare against the live DUT output
   task automatic drain_sb();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() != 0) begin
         e = sb.pop_front();
         case (e.kind)
            c_k_rdata:   obs = csr_rdata;
            c_k_illegal: obs = {31'b0, csr_illegal};
            c_k_rvalid:  obs = {31'b0, redirect_valid};
            default:     obs = redirect_pc;
         endcase
         check_val(e.tag, obs, e.exp);
      end
   endtask

   task automatic idle_inputs();
      csr_en          = 1'b0;
      csr_op          = ZICSR_CSR_OP_NONE;
      csr_addr        = 12'h000;
      csr_wdata       = '0;
      csr_wr_suppress = 1'b0;
      trap_req        = 1'b0;
      trap_cause      = CAUSE_INST_MISALIGNED;
      trap_pc         = '0;
      trap_val        = '0;
      mret            = 1'b0;
   endtask

   // One Zicsr instruction: drive just after an edge, check mid-cycle, retire at next edge
   task automatic csr_cycle(input string tag, input zicsr_csr_op_t op, input logic [11:0] addr,
                            input logic [31:0] wd, input logic sup,
                            input logic [31:0] exp_rd, input logic exp_ill);
      csr_en          = 1'b1;
      csr_op          = op;
      csr_addr        = addr;
      csr_wdata       = wd;
      csr_wr_suppress = sup;
      expect_out({tag, ".rdata"}, c_k_rdata, exp_rd);
      expect_out({tag, ".illegal"}, c_k_illegal, {31'b0, exp_ill});
      #3;
      drain_sb();
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic csr_read(input string tag, input logic [11:0] addr, input logic [31:0] exp_rd);
      csr_cycle(tag, ZICSR_CSR_OP_RS, addr, 32'h0, 1'b1, exp_rd, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      idle_inputs();
      rst = 1'b1;
      @(posedge clk);
      #1;
      expect_out("rst.rvalid", c_k_rvalid, 32'h0);
      expect_out("rst.rpc", c_k_rpc, 32'h0);
      drain_sb();
      rst = 1'b0;

      // Reset contents
      csr_read("rst.mtvec",  ZICSR_CSR_MTVEC,  32'h0);
      csr_read("rst.mepc",   ZICSR_CSR_MEPC,   32'h0);
      csr_read("rst.mcause", ZICSR_CSR_MCAUSE, 32'h0);
      csr_read("rst.mtval",  ZICSR_CSR_MTVAL,  32'h0);

      // CSRRW mtvec with low bits forced to zero
      csr_cycle("rw.mtvec", ZICSR_CSR_OP_RW, ZICSR_CSR_MTVEC, 32'h8000_0103, 1'b0, 32'h0, 1'b0);
      csr_read("rd.mtvec", ZICSR_CSR_MTVEC, 32'h8000_0100);

      // CSRRC on mcause, then suppressed RC/RS leave it alone
      csr_cycle("rw.mcause", ZICSR_CSR_OP_RW, ZICSR_CSR_MCAUSE, 32'hF0, 1'b0, 32'h0, 1'b0);
      csr_cycle("rc.mcause", ZICSR_CSR_OP_RC, ZICSR_CSR_MCAUSE, 32'h30, 1'b0, 32'hF0, 1'b0);
      csr_read("rd.mcause.c0", ZICSR_CSR_MCAUSE, 32'hC0);
      csr_cycle("rc.sup", ZICSR_CSR_OP_RC, ZICSR_CSR_MCAUSE, 32'h30, 1'b1, 32'hC0, 1'b0);
      csr_cycle("rs.sup", ZICSR_CSR_OP_RS, ZICSR_CSR_MCAUSE, 32'hFF, 1'b1, 32'hC0, 1'b0);
      csr_read("rd.mcause.keep", ZICSR_CSR_MCAUSE, 32'hC0);

      // RW writes even with suppress set; RS ORs in
      csr_cycle("rw.sup.mtval", ZICSR_CSR_OP_RW, ZICSR_CSR_MTVAL, 32'h5, 1'b1, 32'h0, 1'b0);
      csr_cycle("rs.mtval", ZICSR_CSR_OP_RS, ZICSR_CSR_MTVAL, 32'h30, 1'b0, 32'h5, 1'b0);
      csr_read("rd.mtval.35", ZICSR_CSR_MTVAL, 32'h35);

      // mepc alignment
      csr_cycle("rw.mepc", ZICSR_CSR_OP_RW, ZICSR_CSR_MEPC, 32'h1007, 1'b0, 32'h0, 1'b0);
      csr_read("rd.mepc.align", ZICSR_CSR_MEPC, 32'h1004);

      // Trap entry with mtvec=0x200
      csr_cycle("rw.mtvec200", ZICSR_CSR_OP_RW, ZICSR_CSR_MTVEC, 32'h200, 1'b0, 32'h8000_0100, 1'b0);
      trap_req   = 1'b1;
      trap_cause = CAUSE_ILLEGAL_INST;
      trap_pc    = 32'h1004;
      trap_val   = 32'hDEAD;
      @(posedge clk);
      #1;
      expect_out("trap.rvalid", c_k_rvalid, 32'h1);
      expect_out("trap.rpc", c_k_rpc, 32'h200);
      // Everything offered during the flush cycle must be dropped
      trap_pc         = 32'h3000;
      trap_val        = 32'hBEEF;
      mret            = 1'b1;
      csr_en          = 1'b1;
      csr_op          = ZICSR_CSR_OP_RW;
      csr_addr        = ZICSR_CSR_MTVAL;
      csr_wdata       = 32'h1111;
      #3;
      drain_sb();
      @(posedge clk);
      #1;
      idle_inputs();
      expect_out("trap.rvalid.drop", c_k_rvalid, 32'h0);
      drain_sb();
      csr_read("trap.mepc",   ZICSR_CSR_MEPC,   32'h1004);
      csr_read("trap.mcause", ZICSR_CSR_MCAUSE, 32'h2);
      csr_read("trap.mtval",  ZICSR_CSR_MTVAL,  32'hDEAD);

      // trap + mret + CSRRW mtvec in one cycle: trap wins, write dropped
      trap_req        = 1'b1;
      trap_cause      = CAUSE_ECALL_M;
      trap_pc         = 32'h2000;
      trap_val        = 32'h0;
      mret            = 1'b1;
      csr_en          = 1'b1;
      csr_op          = ZICSR_CSR_OP_RW;
      csr_addr        = ZICSR_CSR_MTVEC;
      csr_wdata       = 32'h400;
      expect_out("prio.rdata", c_k_rdata, 32'h200);
      #3;
      drain_sb();
      @(posedge clk);
      #1;
      idle_inputs();
      expect_out("prio.rvalid", c_k_rvalid, 32'h1);
      expect_out("prio.rpc", c_k_rpc, 32'h200);
      drain_sb();
      @(posedge clk);
      #1;
      expect_out("prio.rvalid.drop", c_k_rvalid, 32'h0);
      drain_sb();
      csr_read("prio.mtvec",  ZICSR_CSR_MTVEC,  32'h200);
      csr_read("prio.mepc",   ZICSR_CSR_MEPC,   32'h2000);
      csr_read("prio.mcause", ZICSR_CSR_MCAUSE, 32'hB);

      // MRET redirects to mepc; a same-cycle CSR write is dropped
      csr_cycle("rw.mepc1008", ZICSR_CSR_OP_RW, ZICSR_CSR_MEPC, 32'h1008, 1'b0, 32'h2000, 1'b0);
      mret      = 1'b1;
      csr_en    = 1'b1;
      csr_op    = ZICSR_CSR_OP_RW;
      csr_addr  = ZICSR_CSR_MTVAL;
      csr_wdata = 32'h77;
      #3;
      @(posedge clk);
      #1;
      idle_inputs();
      expect_out("mret.rvalid", c_k_rvalid, 32'h1);
      expect_out("mret.rpc", c_k_rpc, 32'h1008);
      drain_sb();
      @(posedge clk);
      #1;
      expect_out("mret.rvalid.drop", c_k_rvalid, 32'h0);
      drain_sb();
      csr_read("mret.mepc",  ZICSR_CSR_MEPC,  32'h1008);
      csr_read("mret.mtval", ZICSR_CSR_MTVAL, 32'h0);

      // Reset asserted mid-redirect kills the pulse at once
      mret = 1'b1;
      @(posedge clk);
      #1;
      mret = 1'b0;
      expect_out("rstr.rvalid.pre", c_k_rvalid, 32'h1);
      drain_sb();
      #1;
      rst = 1'b1;
      #1;
      expect_out("rstr.rvalid", c_k_rvalid, 32'h0);
      expect_out("rstr.rpc", c_k_rpc, 32'h0);
      drain_sb();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      csr_read("rstr.mtvec",  ZICSR_CSR_MTVEC,  32'h0);
      csr_read("rstr.mepc",   ZICSR_CSR_MEPC,   32'h0);
      csr_read("rstr.mcause", ZICSR_CSR_MCAUSE, 32'h0);

      // Unimplemented address
      csr_cycle("unimp.300", ZICSR_CSR_OP_RW, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1);

      // mscratch, present only with the feature macro
`ifdef COTM32_CSR_MSCRATCH_EN
      csr_cycle("mscratch.rs", ZICSR_CSR_OP_RS, ZICSR_CSR_MSCRATCH, 32'h5, 1'b0, 32'h0, 1'b0);
      csr_cycle("mscratch.rd", ZICSR_CSR_OP_RS, ZICSR_CSR_MSCRATCH, 32'h0, 1'b1, 32'h5, 1'b0);
`else
      csr_cycle("mscratch.rs", ZICSR_CSR_OP_RS, ZICSR_CSR_MSCRATCH, 32'h5, 1'b0, 32'h0, 1'b1);
      csr_cycle("mscratch.rd", ZICSR_CSR_OP_RS, ZICSR_CSR_MSCRATCH, 32'h0, 1'b1, 32'h0, 1'b1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
